ahb_switch_arbiter: RTL
=======================

Name: ahb_switch_arbiter

Overview:
Parametrised per-slave-port arbiter for the next-generation multi-layer AHB3-Lite switch. It replaces the fixed highest-priority grant logic with a selectable arbitration mode: fixed priority, round-robin, or priority with round-robin among equal priorities. It is burst-aware and lock-aware, and adds starvation protection. One instance sits in each slave port; it receives request and transfer-control signals from every master port and returns a registered one-hot grant.

Parameters:
MASTERS, 3, number of master ports arbitrated (1..16)
ARB_MODE, 2, 0 = fixed priority; 1 = pure round-robin (priority ignored); 2 = priority, then round-robin among ties
STARVE_LIMIT, 16, number of arbitration cycles a requester may be denied before it is boosted; 0 disables boosting
CNT_W, 5, width of each starvation counter; must satisfy 2^CNT_W > STARVE_LIMIT

Ports:
HCLK  input  1  clock
HRESET  input  1  synchronous reset, active-high
mst_req  input  MASTERS  master m requests this slave port (HSEL decoded, HTRANS != IDLE)
mst_priority  input  3*MASTERS  per-master priority, 7 = highest
mst_HTRANS  input  2*MASTERS  per-master HTRANS
mst_HBURST  input  3*MASTERS  per-master HBURST
mst_HMASTLOCK  input  MASTERS  per-master HMASTLOCK
HREADY  input  1  slave-side HREADY; arbitration and beat tracking advance only when high
grant  output  MASTERS  one-hot current owner
grant_idx  output  $clog2(MASTERS) (min 1)  binary index of owner
switched  output  1  one-cycle pulse: owner changed this cycle
starved  output  MASTERS  master is currently boosted

Behaviour:
- Reset (HRESET high at a HCLK edge):
  - grant = 1 (master 0 parked), grant_idx = 0, switched = 0, starved = 0.
  - rr pointer = MASTERS-1, so master 0 is first in round-robin order.
  - Beat counter = 0; all starvation counters = 0.
  - Reset asserted mid-burst or mid-lock aborts the tenure unconditionally.
- An arbitration cycle is any cycle with HREADY = 1.
- Owner o is switchable in an arbitration cycle iff all of the following hold:
  - mst_HMASTLOCK[o] = 0;
  - the beat counter is 0;
  - mst_HTRANS[o] is IDLE(0) or NONSEQ(2), or mst_req[o] = 0.
  - BUSY(1) and SEQ(3) hold ownership.
- Beat counter (owner only, updated on arbitration cycles):
  - On NONSEQ with HBURST = WRAP4/INCR4 (2,3), load 3; WRAP8/INCR8 (4,5), load 7; WRAP16/INCR16 (6,7), load 15.
  - On SEQ, decrement (saturate at 0). BUSY holds the count.
  - SINGLE and INCR load 0; INCR ownership ends only at IDLE/NONSEQ.
- Selection when switchable and any mst_req is set:
  - Effective class = 8 if starved[m], else mst_priority[m]. In ARB_MODE 1 the class is 0 for non-starved masters.
  - Take the set of requesters with the maximum class.
  - Fixed mode: lowest index wins.
  - Modes 1 and 2: the first index strictly after the rr pointer wins, wrapping modulo MASTERS.
- Grant timing:
  - grant, grant_idx and the rr pointer update on the HCLK edge ending the arbitration cycle.
  - The new owner drives its address phase in the following cycle.
  - switched = 1 for exactly that following cycle when the new owner differs from the old one.
  - Re-grant to the same master leaves switched = 0.
- If no master requests, the grant parks on the current owner with no change and no pulse.
- If HREADY = 0, nothing updates: grant, counters and pointer hold.
- Starvation counters (STARVE_LIMIT > 0), evaluated per arbitration cycle:
  - counter[m] increments (saturating) when mst_req[m] = 1 and m is not granted.
  - It clears when m is granted or mst_req[m] = 0.
  - starved[m] = (counter[m] >= STARVE_LIMIT), registered.
- A lock still blocks switching even when some master is starved. The starved master is granted at the first switchable arbitration cycle.
- When multiple masters are starved, all are class 8 and the normal tie-break applies.
- MASTERS = 1: grant is constantly 1, switched is constantly 0, and no counters are generated.

Test Plan:
- MASTERS=3, ARB_MODE=0, priorities {1,5,5}, all request with NONSEQ SINGLE and HREADY=1 -> grant=010 on cycle 1 and remains 010 while all keep requesting.
- ARB_MODE=2, same priorities, SINGLE transfers -> grant sequence 010, 100, 010, 100 with switched=1 on each change; master 0 stays ungranted until starved.
- ARB_MODE=2, STARVE_LIMIT=4, case as above -> starved[0]=1 after 4 denied cycles; master 0 granted at the next arbitration cycle; starved[0] clears the cycle after the grant.
- Master 1 owns with NONSEQ INCR8 then 7 SEQ (2 BUSY interleaved); master 2 has higher priority and requests from beat 2 -> grant stays 010 through the last SEQ, then switches to 100 with switched pulsing once.
- Master 0 owns with HMASTLOCK=1 for 10 cycles while master 2 is starved -> no switch until HMASTLOCK drops alongside IDLE/NONSEQ, then grant=100.
- HRESET asserted mid-INCR16 (beat 5) with owner master 2 -> next cycle grant=001, grant_idx=0, starved=000, beat counter 0; HREADY=0 for 3 cycles with requests pending -> grant unchanged throughout.

Source files
------------

// File: rtl/ahb_switch_arbiter.sv
// ahb_switch_arbiter: per-slave-port AHB arbiter (fixed/rr/priority-rr, burst+lock aware, starvation boost); in: HCLK HRESET mst_* HREADY, out: grant grant_idx switched starved
module ahb_switch_arbiter #(
  parameter int MASTERS = 3,
  parameter int ARB_MODE = 2,
  parameter int STARVE_LIMIT = 16,
  parameter int CNT_W = 5,
  localparam int IW = (MASTERS > 1) ? $clog2(MASTERS) : 1
) (
  input  logic                 HCLK,
  input  logic                 HRESET,
  input  logic [MASTERS-1:0]   mst_req,
  input  logic [3*MASTERS-1:0] mst_priority,
  input  logic [2*MASTERS-1:0] mst_HTRANS,
  input  logic [3*MASTERS-1:0] mst_HBURST,
  input  logic [MASTERS-1:0]   mst_HMASTLOCK,
  input  logic                 HREADY,
  output logic [MASTERS-1:0]   grant,
  output logic [IW-1:0]        grant_idx,
  output logic                 switched,
  output logic [MASTERS-1:0]   starved
);
  if (MASTERS == 1) begin : g_single
    assign grant = 1'b1;
    assign grant_idx = '0;
    assign switched = 1'b0;
    assign starved = '0;
  end else begin : g_multi
    logic [MASTERS-1:0] r_grant;
    logic [IW-1:0]      r_idx;
    logic [IW-1:0]      r_ptr;
    logic               r_switched;
    logic [3:0]         r_beat;
    logic [MASTERS-1:0] r_starved;
    logic [1:0]         w_htrans [MASTERS];
    logic [2:0]         w_burst [MASTERS];
    logic [3:0]         w_class [MASTERS];
    logic [3:0]         w_max;
    logic [MASTERS-1:0] w_cand;
    logic [IW-1:0]      w_win;
    logic [IW-1:0]      w_next_idx;
    logic [MASTERS-1:0] w_next_grant;
    logic [1:0]         w_own_tr;
    logic [2:0]         w_own_burst;
    logic [3:0]         w_load;
    logic [3:0]         w_beat_next;
    logic               w_switchable;
    logic               w_take;
    always_comb begin
      w_max = '0;
      for (int m = 0; m < MASTERS; m++) begin
        w_htrans[m] = mst_HTRANS[2*m +: 2];
        w_burst[m] = mst_HBURST[3*m +: 3];
        w_class[m] = r_starved[m] ? 4'd8 : (ARB_MODE == 1) ? 4'd0 : {1'b0, mst_priority[3*m +: 3]};
        if (mst_req[m] && w_class[m] > w_max) w_max = w_class[m];
      end
    end
    always_comb begin
      w_cand = '0;
      for (int m = 0; m < MASTERS; m++) w_cand[m] = mst_req[m] && (w_class[m] == w_max);
    end
    // descending scan so the last hit (lowest index / nearest after pointer) wins
    always_comb begin
      w_win = '0;
      if (ARB_MODE == 0) begin
        for (int m = MASTERS - 1; m >= 0; m--) if (w_cand[m]) w_win = IW'(m);
      end else begin
        for (int k = MASTERS; k >= 1; k--)
          if (w_cand[(int'(r_ptr) + k) % MASTERS]) w_win = IW'((int'(r_ptr) + k) % MASTERS);
      end
    end
    assign w_own_tr = w_htrans[r_idx];
    assign w_own_burst = w_burst[r_idx];
    assign w_switchable = !mst_HMASTLOCK[r_idx] && (r_beat == 4'd0) &&
                          (!mst_req[r_idx] || w_own_tr == 2'd0 || w_own_tr == 2'd2);
    assign w_take = HREADY && w_switchable && (|mst_req);
    assign w_next_idx = w_take ? w_win : r_idx;
    assign w_next_grant = MASTERS'(1) << w_next_idx;
    assign w_load = (w_own_burst >= 3'd6) ? 4'd15 : (w_own_burst >= 3'd4) ? 4'd7 :
                    (w_own_burst >= 3'd2) ? 4'd3 : 4'd0;
    // a handover starts the new owner with no burst outstanding
    assign w_beat_next = (w_next_idx != r_idx) ? 4'd0 :
                         (w_own_tr == 2'd2) ? w_load :
                         (w_own_tr == 2'd3) ? ((r_beat == 4'd0) ? 4'd0 : r_beat - 4'd1) :
                         (w_own_tr == 2'd1) ? r_beat : 4'd0;
    always_ff @(posedge HCLK) begin
      if (HRESET) begin
        r_grant <= MASTERS'(1);
        r_idx <= '0;
        r_ptr <= IW'(MASTERS - 1);
        r_switched <= 1'b0;
        r_beat <= '0;
      end else if (HREADY) begin
        r_grant <= w_next_grant;
        r_idx <= w_next_idx;
        r_ptr <= w_take ? w_win : r_ptr;
        r_switched <= (w_next_idx != r_idx);
        r_beat <= w_beat_next;
      end else begin
        r_switched <= 1'b0;
      end
    end
    if (STARVE_LIMIT > 0) begin : g_starve
      logic [CNT_W-1:0] r_cnt [MASTERS];
      logic [CNT_W-1:0] w_cnt_next [MASTERS];
      always_comb begin
        for (int m = 0; m < MASTERS; m++)
          w_cnt_next[m] = (!mst_req[m] || w_next_grant[m]) ? '0 :
                          (&r_cnt[m]) ? r_cnt[m] : r_cnt[m] + CNT_W'(1);
      end
      always_ff @(posedge HCLK) begin
        if (HRESET) begin
          for (int m = 0; m < MASTERS; m++) r_cnt[m] <= '0;
          r_starved <= '0;
        end else if (HREADY) begin
          for (int m = 0; m < MASTERS; m++) begin
            r_cnt[m] <= w_cnt_next[m];
            r_starved[m] <= (w_cnt_next[m] >= CNT_W'(STARVE_LIMIT));
          end
        end
      end
    end else begin : g_no_starve
      assign r_starved = '0;
    end
    assign grant = r_grant;
    assign grant_idx = r_idx;
    assign switched = r_switched;
    assign starved = r_starved;
  end
endmodule
